// File: rtl/instr_rom_loader_pkg.sv
// Shared constants for the instruction-ROM loader: state encoding, default capacity
// and byte/word lane geometry.
package instr_rom_loader_pkg;

   localparam int ROM_BYTES_DEF = 1024;
   localparam int SIZE_W_DEF    = 32;
   localparam int BYTE_W        = 8;
   localparam int WORD_BYTES    = 4;
   localparam int WORD_LSB      = $clog2(WORD_BYTES);

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t LOAD = 2'd1;
   localparam state_t PAD  = 2'd2;
   localparam state_t DONE = 2'd3;

endpackage

// File: rtl/instr_rom_loader.sv
// Packs a valid/ready byte stream little-endian into a flat instruction-ROM image and
// publishes rom_size once the image is complete. Define WORD_PAD_EN to zero-pad to a word.
module instr_rom_loader
   import instr_rom_loader_pkg::*;
#(
   parameter int ROM_BYTES = ROM_BYTES_DEF,
   parameter int SIZE_W    = SIZE_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_byte,
   input  logic                     in_last,
   output logic [ROM_BYTES*8-1:0]   instr_rom,
   output logic [SIZE_W-1:0]        rom_size,
   output logic                     load_done,
   output logic                     overflow
);

   localparam int                AW  = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
   localparam logic [SIZE_W-1:0] CAP = SIZE_W'(ROM_BYTES);

   state_t                           state;
   logic [SIZE_W-1:0]                wptr;
   logic [SIZE_W-1:0]                wptr_nxt;
   logic [ROM_BYTES-1:0][BYTE_W-1:0] rom_q;
   logic [AW-1:0]                    waddr;
   logic [BYTE_W-1:0]                wr_data;
   logic                             xfer;
   logic                             full;
   logic                             wr_en;
   logic                             pad_wr;
   logic                             finish;
   logic                             enter_pad;

   // in_ready depends only on state and start, never on in_valid
   assign in_ready = (state == LOAD) && !start;
   assign xfer     = in_valid && in_ready;
   assign full     = (wptr >= CAP);
   assign wptr_nxt = full ? wptr : wptr + 1'b1;
   assign waddr    = wptr[AW-1:0];

`ifdef WORD_PAD_EN
   logic pad_done;

   // Word boundary (or end of ROM) reached once the pending byte lands
   assign pad_done  = (wptr_nxt[WORD_LSB-1:0] == '0) || (wptr_nxt == CAP);
   assign pad_wr    = (state == PAD) && !start;
   assign finish    = (xfer && in_last && pad_done) || (pad_wr && pad_done);
   assign enter_pad = xfer && in_last && !pad_done;
`else
   assign pad_wr    = 1'b0;
   assign finish    = xfer && in_last;
   assign enter_pad = 1'b0;
`endif

   assign wr_en   = (xfer && !full) || pad_wr;
   assign wr_data = pad_wr ? '0 : in_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_q <= '0;
      end else if (start) begin
         rom_q <= '0;
      end else if (wr_en) begin
         rom_q[waddr] <= wr_data;
      end
   end

   assign instr_rom = rom_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         wptr      <= '0;
         rom_size  <= '0;
         load_done <= 1'b0;
         overflow  <= 1'b0;
      end else if (start) begin
         state     <= LOAD;
         wptr      <= '0;
         rom_size  <= '0;
         load_done <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (xfer && full) begin
            overflow <= 1'b1;
         end
         if (wr_en) begin
            wptr <= wptr_nxt;
         end
         // rom_size is published only when the image is final
         if (finish) begin
            state     <= DONE;
            rom_size  <= wptr_nxt;
            load_done <= 1'b1;
         end else if (enter_pad) begin
            state <= PAD;
         end
      end
   end

endmodule

// File: tb/tb_instr_rom_loader.sv
// Scoreboard bench for instr_rom_loader with randomized programs and a reference model.
module tb_instr_rom_loader;

   localparam int ROM_BYTES = 1024;
   localparam int SIZE_W    = 32;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [ROM_BYTES*8-1:0] img;
      int                     size;
      bit                     ovf;
      int                     pad;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   in_valid;
   logic                   in_ready;
   logic [7:0]             in_byte;
   logic                   in_last;
   logic [ROM_BYTES*8-1:0] instr_rom;
   logic [SIZE_W-1:0]      rom_size;
   logic                   load_done;
   logic                   overflow;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   mon_bad;
   logic prev_done = 1'b0;

   instr_rom_loader #(.ROM_BYTES(ROM_BYTES), .SIZE_W(SIZE_W)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_byte(in_byte), .in_last(in_last), .instr_rom(instr_rom), .rom_size(rom_size),
      .load_done(load_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: image holds the first min(n,ROM) bytes, rest zero; size optionally rounded up to a word
   function automatic exp_t model(input byte_q_t prog);
      exp_t e;
      int   kept;
      kept  = (prog.size() > ROM_BYTES) ? ROM_BYTES : prog.size();
      e.img = '0;
      for (int i = 0; i < kept; i++) e.img[i*8 +: 8] = prog[i];
      e.size = kept;
`ifdef WORD_PAD_EN
      if (e.size % 4 != 0) e.size = e.size + (4 - e.size % 4);
      if (e.size > ROM_BYTES) e.size = ROM_BYTES;
`endif
      e.ovf = (prog.size() > ROM_BYTES);
      e.pad = e.size - kept;
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset && load_done && !prev_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got load_done=1 expected no completion pending");
         end else begin
            mon_e = sb.pop_front();
            chk("rom_size", rom_size, mon_e.size);
            chk("overflow", overflow, mon_e.ovf);
            mon_bad = -1;
            for (int i = 0; i < ROM_BYTES; i++) begin
               if (mon_bad < 0 && instr_rom[i*8 +: 8] !== mon_e.img[i*8 +: 8]) mon_bad = i;
            end
            checks++;
            if (mon_bad >= 0) begin
               errors++;
               $display("FAIL image byte %0d: got %0h expected %0h", mon_bad,
                        instr_rom[mon_bad*8 +: 8], mon_e.img[mon_bad*8 +: 8]);
            end
         end
      end
      prev_done <= load_done;
   end

   // mode 0: always valid, 1: valid every other cycle, 2: random gaps
   task automatic send_prog(input byte_q_t prog, input int mode);
      exp_t e;
      int   i;
      int   cyc;
      int   extra;
      bit   tog;
      bit   v;
      bit   drop;
      e = model(prog);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      start = 1'b0;
      i = 0; cyc = 0; tog = 1'b1; drop = 1'b0;
      while (i < prog.size()) begin
         v        = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
         tog      = !tog;
         in_valid = v;
         in_byte  = v ? prog[i] : 8'($urandom);
         in_last  = v ? (i == prog.size() - 1) : 1'($urandom);
         #1;
         if (!in_ready) drop = 1'b1;
         if (v && in_ready) i++;
         cyc++;
         @(negedge clk);
         if (cyc > 4 * prog.size() + 20) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("all_bytes_accepted", i, prog.size());
      chk("in_ready_held", drop, 1'b0);
      extra = 0;
      while (!load_done && extra < 10) begin
         @(negedge clk);
         extra++;
      end
      chk("done_latency", extra, e.pad);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte_q_t p;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_rom_size", rom_size, 0);
      chk("rst_load_done", load_done, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_rom_zero", instr_rom == '0, 1'b1);

      // Reset mid-load after three bytes
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_byte = 8'hA0 + 8'(k); in_last = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("partial_bytes", instr_rom[23:0], 24'hA2A1A0);
      chk("partial_size", rom_size, 0);
      #2 reset = 1'b0;
      #1;
      chk("midrst_rom_zero", instr_rom == '0, 1'b1);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_load_done", load_done, 1'b0);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_in_ready", in_ready, 1'b0);

      p = {8'h13, 8'h00, 8'h00, 8'h00};
      send_prog(p, 0);
      p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_prog(p, 1);
      for (int r = 0; r < 5; r++) begin
         p.delete();
         for (int k = 0; k < int'($urandom_range(1, 40)); k++) p.push_back(8'($urandom));
         send_prog(p, 2);
      end
      p.delete();
      for (int k = 0; k < ROM_BYTES; k++) p.push_back(8'($urandom));
      send_prog(p, 0);
      p.delete();
      for (int k = 0; k < 1030; k++) p.push_back(8'($urandom));
      send_prog(p, 0);

      // start with a byte offered while in DONE
      @(negedge clk);
      chk("in_done", load_done, 1'b1);
      start = 1'b1; in_valid = 1'b1; in_byte = 8'hAA; in_last = 1'b1;
      #1;
      chk("done_start_ready", in_ready, 1'b0);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      #1;
      chk("restart_size", rom_size, 0);
      chk("restart_done", load_done, 1'b0);
      chk("restart_ovf", overflow, 1'b0);
      chk("restart_rom_zero", instr_rom == '0, 1'b1);

      // start mid-load while a byte is offered
      @(negedge clk);
      in_valid = 1'b1; in_byte = 8'h11;
      @(negedge clk);
      start = 1'b1; in_byte = 8'h5A;
      #1;
      chk("midload_start_ready", in_ready, 1'b0);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      #1;
      chk("midload_rom_zero", instr_rom == '0, 1'b1);

      p = {8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8};
      send_prog(p, 0);
      p = {8'h21, 8'h22, 8'h23, 8'h24};
      send_prog(p, 2);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
